// File: rtl/ysyx_23060077_muldiv_ctrl_pkg.sv
// Shared definitions for the M-extension controller: FSM states, multiplier
// signedness selects, result selects and the default datapath width.
package ysyx_23060077_muldiv_ctrl_pkg;

  localparam int MULDIV_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RES_LO   = 2'd0,
    RES_HI   = 2'd1,
    RES_QUOT = 2'd2,
    RES_REM  = 2'd3
  } res_sel_e;

  // {src1 signed, src2 signed}
  localparam logic [1:0] MUL_SIGNED_SS = 2'b11;
  localparam logic [1:0] MUL_SIGNED_SU = 2'b10;
  localparam logic [1:0] MUL_SIGNED_UU = 2'b00;

endpackage

// File: rtl/ysyx_23060077_muldiv_ctrl_if.sv
// Request/response bus plus multiplier and divider handshakes of the controller.
// master = controller view, slave = EXU and arithmetic-unit view.
interface ysyx_23060077_muldiv_ctrl_if
  import ysyx_23060077_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = MULDIV_DATA_WIDTH
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_is_div;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_src1;
  logic [DATA_WIDTH-1:0] req_src2;
  logic                  flush;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  mul_valid;
  logic                  mul_ready;
  logic                  mul_out_valid;
  logic [1:0]            mul_signed;
  logic                  mul_flush;
  logic [DATA_WIDTH-1:0] mul_a;
  logic [DATA_WIDTH-1:0] mul_b;
  logic [DATA_WIDTH-1:0] mul_res_hi;
  logic [DATA_WIDTH-1:0] mul_res_lo;
  logic                  div_valid;
  logic                  div_ready;
  logic                  div_out_valid;
  logic                  div_signed;
  logic                  div_flush;
  logic [DATA_WIDTH-1:0] div_a;
  logic [DATA_WIDTH-1:0] div_b;
  logic [DATA_WIDTH-1:0] div_quot;
  logic [DATA_WIDTH-1:0] div_rem;

  modport master (
    input  req_valid, req_is_div, req_funct3, req_src1, req_src2, flush, resp_ready,
    input  mul_ready, mul_out_valid, mul_res_hi, mul_res_lo,
    input  div_ready, div_out_valid, div_quot, div_rem,
    output req_ready, resp_valid, resp_data,
    output mul_valid, mul_signed, mul_flush, mul_a, mul_b,
    output div_valid, div_signed, div_flush, div_a, div_b
  );

  modport slave (
    output req_valid, req_is_div, req_funct3, req_src1, req_src2, flush, resp_ready,
    output mul_ready, mul_out_valid, mul_res_hi, mul_res_lo,
    output div_ready, div_out_valid, div_quot, div_rem,
    input  req_ready, resp_valid, resp_data,
    input  mul_valid, mul_signed, mul_flush, mul_a, mul_b,
    input  div_valid, div_signed, div_flush, div_a, div_b
  );

endinterface

// File: rtl/ysyx_23060077_muldiv_decode.sv
// Combinational RV32M decode: unit signedness, result select, and the fast-path
// detection (illegal pairing, divide by zero, signed overflow) with its result.
module ysyx_23060077_muldiv_decode
  import ysyx_23060077_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = MULDIV_DATA_WIDTH
) (
  input  logic                  is_div,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  output logic [1:0]            mul_signed,
  output logic                  div_signed,
  output res_sel_e              res_sel,
  output logic                  fast,
  output logic [DATA_WIDTH-1:0] fast_res
);

  localparam logic [DATA_WIDTH-1:0] INT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

  logic bad_pair;
  logic div_zero;
  logic div_ovf;

  always_comb begin
    mul_signed = MUL_SIGNED_UU;
    div_signed = 1'b0;
    res_sel    = RES_LO;
    unique case (funct3)
      3'b000: begin mul_signed = MUL_SIGNED_SS; res_sel = RES_LO;   end
      3'b001: begin mul_signed = MUL_SIGNED_SS; res_sel = RES_HI;   end
      3'b010: begin mul_signed = MUL_SIGNED_SU; res_sel = RES_HI;   end
      3'b011: begin mul_signed = MUL_SIGNED_UU; res_sel = RES_HI;   end
      3'b100: begin div_signed = 1'b1;          res_sel = RES_QUOT; end
      3'b101: begin div_signed = 1'b0;          res_sel = RES_QUOT; end
      3'b110: begin div_signed = 1'b1;          res_sel = RES_REM;  end
      3'b111: begin div_signed = 1'b0;          res_sel = RES_REM;  end
    endcase
  end

  // funct3[2] must agree with is_div; otherwise the op retires as 0 without a unit
  assign bad_pair = is_div ^ funct3[2];
  assign div_zero = is_div & funct3[2] & (src2 == '0);
  assign div_ovf  = is_div & funct3[2] & ~funct3[0] & (src1 == INT_MIN) & (src2 == ALL_ONES);
  assign fast     = bad_pair | div_zero | div_ovf;

  always_comb begin
    fast_res = '0;
    if (bad_pair)      fast_res = '0;
    else if (div_zero) fast_res = funct3[1] ? src1 : ALL_ONES;
    else if (div_ovf)  fast_res = funct3[1] ? '0 : INT_MIN;
  end

endmodule

// File: rtl/ysyx_23060077_muldiv_ctrl.sv
// M-extension sequencer: accepts one op from the EXU, drives the multiplier or
// divider handshake (or answers special cases directly), and returns the result.
module ysyx_23060077_muldiv_ctrl
  import ysyx_23060077_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = MULDIV_DATA_WIDTH
) (
  input logic                        clock,
  input logic                        reset,
  ysyx_23060077_muldiv_ctrl_if.master bus
);

  state_e                state_q;
  logic                  idle_q;
  logic                  is_div_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] src1_q;
  logic [DATA_WIDTH-1:0] src2_q;
  logic [DATA_WIDTH-1:0] res_q;

  logic                  in_idle;
  logic                  busy;
  logic                  accept;
  logic                  sel_ready;
  logic                  sel_out_valid;
  logic [DATA_WIDTH-1:0] unit_res;

  logic                  dec_is_div;
  logic [2:0]            dec_funct3;
  logic [DATA_WIDTH-1:0] dec_src1;
  logic [DATA_WIDTH-1:0] dec_src2;
  logic [1:0]            dec_mul_signed;
  logic                  dec_div_signed;
  res_sel_e              dec_res_sel;
  logic                  dec_fast;
  logic [DATA_WIDTH-1:0] dec_fast_res;

  assign in_idle = (state_q == ST_IDLE);
  assign busy    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign accept  = bus.req_valid && bus.req_ready;

  // One decoder: it looks at the incoming request while idle (fast-path
  // decision) and at the latched request for the rest of the operation.
  assign dec_is_div = in_idle ? bus.req_is_div : is_div_q;
  assign dec_funct3 = in_idle ? bus.req_funct3 : funct3_q;
  assign dec_src1   = in_idle ? bus.req_src1   : src1_q;
  assign dec_src2   = in_idle ? bus.req_src2   : src2_q;

  ysyx_23060077_muldiv_decode #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_decode (
    .is_div     (dec_is_div),
    .funct3     (dec_funct3),
    .src1       (dec_src1),
    .src2       (dec_src2),
    .mul_signed (dec_mul_signed),
    .div_signed (dec_div_signed),
    .res_sel    (dec_res_sel),
    .fast       (dec_fast),
    .fast_res   (dec_fast_res)
  );

  assign sel_ready     = is_div_q ? bus.div_ready     : bus.mul_ready;
  assign sel_out_valid = is_div_q ? bus.div_out_valid : bus.mul_out_valid;

  always_comb begin
    unit_res = '0;
    unique case (dec_res_sel)
      RES_LO:   unit_res = bus.mul_res_lo;
      RES_HI:   unit_res = bus.mul_res_hi;
      RES_QUOT: unit_res = bus.div_quot;
      RES_REM:  unit_res = bus.div_rem;
    endcase
  end

  // idle_q tracks "next state is IDLE" so req_ready stays low through reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idle_q   <= 1'b0;
      is_div_q <= 1'b0;
      funct3_q <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      res_q    <= '0;
    end else if (bus.flush) begin
      state_q <= ST_IDLE;
      idle_q  <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          idle_q <= 1'b1;
          if (accept) begin
            is_div_q <= bus.req_is_div;
            funct3_q <= bus.req_funct3;
            src1_q   <= bus.req_src1;
            src2_q   <= bus.req_src2;
            idle_q   <= 1'b0;
            if (dec_fast) begin
              res_q   <= dec_fast_res;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (sel_ready) begin
            if (sel_out_valid) begin
              res_q   <= unit_res;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (sel_out_valid) begin
            res_q   <= unit_res;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.resp_ready) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.req_ready  = idle_q && !bus.flush;
  assign bus.resp_valid = (state_q == ST_DONE);
  assign bus.resp_data  = res_q;

  assign bus.mul_valid  = (state_q == ST_ISSUE) && !is_div_q;
  assign bus.div_valid  = (state_q == ST_ISSUE) &&  is_div_q;
  assign bus.mul_signed = in_idle ? 2'b00 : dec_mul_signed;
  assign bus.div_signed = !in_idle && dec_div_signed;
  assign bus.mul_flush  = bus.flush && busy && !is_div_q;
  assign bus.div_flush  = bus.flush && busy &&  is_div_q;
  assign bus.mul_a      = src1_q;
  assign bus.mul_b      = src2_q;
  assign bus.div_a      = src1_q;
  assign bus.div_b      = src2_q;

endmodule

// File: tb/tb_ysyx_23060077_muldiv_ctrl.sv
// Bench for the M-extension controller: directed vector table, random ops
// against an RV32M reference model, plus flush and reset sequences.
module tb_ysyx_23060077_muldiv_ctrl;
  localparam int W = 32;
  localparam logic [W-1:0] IMIN = 32'h8000_0000;
  localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ysyx_23060077_muldiv_ctrl_if #(.DATA_WIDTH(W)) bus ();

  ysyx_23060077_muldiv_ctrl #(.DATA_WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // RV32M semantics straight from the instruction definition
  function automatic logic [W-1:0] ref_model(input bit is_div, input bit [2:0] f3,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    bit ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ovf = (a == IMIN) && (b == ONES);
    if (is_div != f3[2]) return '0;
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0];  end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: return (b == 0) ? ONES : ovf ? IMIN : W'($signed(a) / $signed(b));
      3'b101: return (b == 0) ? ONES : a / b;
      3'b110: return (b == 0) ? a : ovf ? '0 : W'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_fast(input bit is_div, input bit [2:0] f3,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
    if (is_div != f3[2]) return 1'b1;
    if (is_div && b == 0) return 1'b1;
    if (is_div && !f3[0] && a == IMIN && b == ONES) return 1'b1;
    return 1'b0;
  endfunction

  // behavioural arithmetic units answering the controller's handshakes
  function automatic logic [63:0] mul_unit(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] sg);
    logic [63:0] ea, eb;
    ea = sg[1] ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sg[0] ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] div_unit(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sg);
    if (b == 0) return {ONES, a};
    if (sg) return {W'($signed(a) / $signed(b)), W'($signed(a) % $signed(b))};
    return {a / b, a % b};
  endfunction

  task automatic clear_units();
    bus.mul_ready = 0; bus.mul_out_valid = 0; bus.mul_res_hi = '0; bus.mul_res_lo = '0;
    bus.div_ready = 0; bus.div_out_valid = 0; bus.div_quot = '0; bus.div_rem = '0;
  endtask

  task automatic run_op(input bit is_div, input bit [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input bit exp_fast,
                        input int rdy_dly, input int ov_dly, input int resp_dly, input string tag);
    int n, issue_cnt, hs_c, ov_c, resp_c, bad_other, bad_ops, bad_hold;
    bit hs, ovd, got;
    logic [1:0] exp_msig;
    logic [63:0] p;
    issue_cnt = 0; hs_c = 0; ov_c = 0; resp_c = -1;
    bad_other = 0; bad_ops = 0; bad_hold = 0; hs = 0; ovd = 0; got = 0;
    exp_msig = (f3[1:0] == 2'b10) ? 2'b10 : (f3[1:0] == 2'b11) ? 2'b00 : 2'b11;
    @(negedge clock);
    bus.req_valid = 1; bus.req_is_div = is_div; bus.req_funct3 = f3;
    bus.req_src1 = a; bus.req_src2 = b;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clock); n++; end
    check({tag, " accept"}, 64'(n < 20), 1);
    @(posedge clock); #1;
    bus.req_valid = 0; bus.req_src1 = $urandom; bus.req_src2 = $urandom;
    bus.req_funct3 = 3'($urandom); bus.req_is_div = 1'($urandom);
    for (int c = 0; c < 60 && !got; c++) begin
      if (is_div) begin
        bus.div_ready = 0; bus.div_out_valid = 0;
        bus.mul_ready = 1'($urandom_range(0, 1)); bus.mul_out_valid = 1'($urandom_range(0, 1));
        bus.mul_res_hi = $urandom; bus.mul_res_lo = $urandom;
        if (bus.mul_valid) bad_other++;
        if (bus.div_valid) begin
          issue_cnt++;
          if (bus.div_a !== a || bus.div_b !== b || bus.div_signed !== ~f3[0]) bad_ops++;
          if (!hs && issue_cnt > rdy_dly) begin hs = 1; hs_c = c; bus.div_ready = 1; end
        end
        if (hs && !ovd && c == hs_c + ov_dly) begin
          ovd = 1; ov_c = c; p = div_unit(bus.div_a, bus.div_b, bus.div_signed);
          bus.div_out_valid = 1; bus.div_quot = p[63:32]; bus.div_rem = p[31:0];
        end
      end else begin
        bus.mul_ready = 0; bus.mul_out_valid = 0;
        bus.div_ready = 1'($urandom_range(0, 1)); bus.div_out_valid = 1'($urandom_range(0, 1));
        bus.div_quot = $urandom; bus.div_rem = $urandom;
        if (bus.div_valid) bad_other++;
        if (bus.mul_valid) begin
          issue_cnt++;
          if (bus.mul_a !== a || bus.mul_b !== b || bus.mul_signed !== exp_msig) bad_ops++;
          if (!hs && issue_cnt > rdy_dly) begin hs = 1; hs_c = c; bus.mul_ready = 1; end
        end
        if (hs && !ovd && c == hs_c + ov_dly) begin
          ovd = 1; ov_c = c; p = mul_unit(bus.mul_a, bus.mul_b, bus.mul_signed);
          bus.mul_out_valid = 1; bus.mul_res_hi = p[63:32]; bus.mul_res_lo = p[31:0];
        end
      end
      #1;
      if (bus.resp_valid) begin
        got = 1; resp_c = c;
        if (bus.req_ready) bad_hold++;
      end else begin
        @(posedge clock); #1;
      end
    end
    check({tag, " resp_seen"}, 64'(got), 1);
    check({tag, " other_unit_valid"}, 64'(bad_other), 0);
    if (exp_fast) begin
      check({tag, " fast_latency"}, 64'(resp_c), 0);
      check({tag, " fast_no_unit"}, 64'(issue_cnt), 0);
    end else begin
      check({tag, " latency"}, 64'(resp_c), 64'(ov_c + 1));
      check({tag, " issue_cycles"}, 64'(issue_cnt), 64'(rdy_dly + 1));
      check({tag, " operands"}, 64'(bad_ops), 0);
    end
    check({tag, " data"}, 64'(bus.resp_data), 64'(exp));
    clear_units();
    for (int k = 0; k < resp_dly; k++) begin
      @(posedge clock); #1;
      bus.mul_out_valid = 1; bus.mul_res_lo = $urandom; bus.mul_res_hi = $urandom;
      bus.div_out_valid = 1; bus.div_quot = $urandom; bus.div_rem = $urandom;
      #1;
      if (!bus.resp_valid || bus.resp_data !== exp || bus.req_ready) bad_hold++;
    end
    clear_units();
    bus.resp_ready = 1;
    @(posedge clock); #1;
    bus.resp_ready = 0;
    if (bus.resp_valid) bad_hold++;
    check({tag, " hold_retire"}, 64'(bad_hold), 0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return IMIN;
      2: return ONES;
      3: return W'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    bit         is_div;
    bit [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    bit         fast;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  initial begin
    bus.req_valid = 0; bus.req_is_div = 0; bus.req_funct3 = '0;
    bus.req_src1 = '0; bus.req_src2 = '0; bus.flush = 0; bus.resp_ready = 0;
    clear_units();

    vt[0]  = '{0, 3'b000, 32'd7,        32'd6,        32'd42,       0};
    vt[1]  = '{0, 3'b001, ONES,         ONES,         32'h0,        0};
    vt[2]  = '{0, 3'b011, ONES,         ONES,         32'hFFFFFFFE, 0};
    vt[3]  = '{0, 3'b010, ONES,         ONES,         32'hFFFFFFFF, 0};
    vt[4]  = '{0, 3'b001, IMIN,         IMIN,         32'h40000000, 0};
    vt[5]  = '{0, 3'b000, IMIN,         ONES,         32'h80000000, 0};
    vt[6]  = '{1, 3'b100, IMIN,         ONES,         32'h80000000, 1};
    vt[7]  = '{1, 3'b110, IMIN,         ONES,         32'h0,        1};
    vt[8]  = '{1, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vt[9]  = '{1, 3'b111, 32'd5,        32'd0,        32'd5,        1};
    vt[10] = '{1, 3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1};
    vt[11] = '{1, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0};
    vt[12] = '{1, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0};
    vt[13] = '{1, 3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 0};
    vt[14] = '{1, 3'b101, IMIN,         ONES,         32'h0,        0};
    vt[15] = '{0, 3'b100, 32'd7,        32'd6,        32'h0,        1};
    vt[16] = '{1, 3'b001, 32'd7,        32'd6,        32'h0,        1};
    vt[17] = '{1, 3'b111, IMIN,         ONES,         32'h80000000, 0};

    // reset state
    #12;
    check("rst req_ready", 64'(bus.req_ready), 0);
    check("rst resp_valid", 64'(bus.resp_valid), 0);
    check("rst resp_data", 64'(bus.resp_data), 0);
    check("rst unit_valid", 64'({bus.mul_valid, bus.div_valid, bus.mul_flush, bus.div_flush}), 0);
    @(negedge clock); reset = 1;
    @(posedge clock); #1;
    check("post_rst req_ready", 64'(bus.req_ready), 1);

    for (int i = 0; i < NV; i++)
      run_op(vt[i].is_div, vt[i].f3, vt[i].a, vt[i].b, vt[i].exp, vt[i].fast,
             i % 3, (i == 0) ? 3 : i % 4, i % 2, $sformatf("vec%0d", i));

    // MULHU stalled on mul_ready for 4 cycles, response held 5 cycles
    run_op(0, 3'b011, 32'hDEAD_BEEF, 32'h1234_5678,
           ref_model(0, 3'b011, 32'hDEAD_BEEF, 32'h1234_5678), 0, 4, 1, 5, "mulhu_stall");

    // flush during DIV wait: one-cycle div_flush, late out_valid ignored
    @(negedge clock);
    bus.req_valid = 1; bus.req_is_div = 1; bus.req_funct3 = 3'b100;
    bus.req_src1 = 32'd100; bus.req_src2 = 32'd7;
    @(posedge clock); #1;
    bus.req_valid = 0;
    check("fl issue div_valid", 64'(bus.div_valid), 1);
    bus.div_ready = 1;
    @(posedge clock); #1;
    bus.div_ready = 0; bus.flush = 1; #1;
    check("fl wait flush_pulse", 64'({bus.div_flush, bus.mul_flush}), 64'(2'b10));
    check("fl wait req_ready", 64'(bus.req_ready), 0);
    @(posedge clock); #1;
    bus.flush = 0; bus.div_out_valid = 1; bus.div_quot = 32'h1234; #1;
    check("fl after div_flush", 64'(bus.div_flush), 0);
    check("fl after req_ready", 64'(bus.req_ready), 1);
    @(posedge clock); #1;
    bus.div_out_valid = 0; #1;
    check("fl late out_valid ignored", 64'({bus.resp_valid, bus.div_valid}), 0);
    run_op(1, 3'b100, 32'd100, 32'd7, 32'd14, 0, 0, 1, 0, "fl next_div");

    // flush while DONE: response withdrawn, no unit flush
    @(negedge clock);
    bus.req_valid = 1; bus.req_is_div = 1; bus.req_funct3 = 3'b111;
    bus.req_src1 = 32'd5; bus.req_src2 = 32'd0;
    @(posedge clock); #1;
    bus.req_valid = 0;
    check("fd resp_valid", 64'(bus.resp_valid), 1);
    bus.flush = 1; #1;
    check("fd no unit flush", 64'({bus.mul_flush, bus.div_flush}), 0);
    @(posedge clock); #1;
    bus.flush = 0; #1;
    check("fd resp dropped", 64'(bus.resp_valid), 0);

    // reset in the middle of a MUL wait
    @(negedge clock);
    bus.req_valid = 1; bus.req_is_div = 0; bus.req_funct3 = 3'b000;
    bus.req_src1 = 32'd3; bus.req_src2 = 32'd4;
    @(posedge clock); #1;
    bus.req_valid = 0; bus.mul_ready = 1;
    @(posedge clock); #1;
    bus.mul_ready = 0;
    reset = 0; #1;
    check("mid_rst ready_valid", 64'({bus.req_ready, bus.resp_valid, bus.mul_valid, bus.div_valid}), 0);
    check("mid_rst flushes", 64'({bus.mul_flush, bus.div_flush}), 0);
    check("mid_rst resp_data", 64'(bus.resp_data), 0);
    check("mid_rst mul_a", 64'(bus.mul_a), 0);
    @(negedge clock); @(negedge clock); reset = 1;
    @(posedge clock); #1;
    check("mid_rst release", 64'({bus.req_ready, bus.resp_valid}), 64'(2'b10));

    // random ops against the reference model
    for (int i = 0; i < 150; i++) begin
      bit d;
      bit [2:0] f;
      logic [W-1:0] a, b;
      d = 1'($urandom_range(0, 1));
      f = {d, 2'($urandom)};
      if ($urandom_range(0, 15) == 0) f = 3'($urandom);
      a = pick_operand();
      b = pick_operand();
      run_op(d, f, a, b, ref_model(d, f, a, b), ref_fast(d, f, a, b),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
             $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
